afpm_operand_loader: RTL
========================

AFPM_OPERAND_LOADER -- requirements
Module: afpm_operand_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of operand-pair FIFO entries; legal values are 2 and 4.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 ena  input  1  design enable; when low, no byte is accepted and no pop occurs.
REQ-005 ui_in  input  8  operand A byte, low byte first.
REQ-006 uio_in  input  8  operand B byte, low byte first.
REQ-007 in_valid  input  1  the byte pair on ui_in/uio_in is valid this cycle.
REQ-008 in_ready  output  1  the loader can accept a byte pair this cycle.
REQ-009 frame_clr  input  1  synchronous resynchronisation strobe.
REQ-010 op_a  output  16  assembled FP16 operand A.
REQ-011 op_b  output  16  assembled FP16 operand B.
REQ-012 op_valid  output  1  the FIFO head is valid.
REQ-013 op_ready  input  1  the multiplier core consumes the head.
REQ-014 op_zero  output  1  the head has exponent==0 in A or B.
REQ-015 op_infnan  output  1  the head has exponent==31 in A or B.
REQ-016 drop_err  output  1  sticky flag: a byte pair was offered while in_ready was low.

Function
REQ-017 A byte pair SHALL be accepted when in_valid, in_ready and ena are all high.
REQ-018 A phase bit SHALL toggle on each accepted byte pair. In phase 0, the bytes load the low holding registers. In phase 1, {ui_in, hold_a} and {uio_in, hold_b} are pushed into the FIFO.
REQ-019 in_ready SHALL equal ena AND (phase==0 OR FIFO not full OR (op_valid AND op_ready)), so that a push and a pop can occur in the same cycle when the FIFO is full.
REQ-020 op_valid SHALL assert on the first edge after the edge that accepts the high byte, giving 1-cycle latency, and never combinationally from the inputs.
REQ-021 The head SHALL be popped when op_valid, op_ready and ena are all high. op_a, op_b and the flags SHALL hold stable while op_valid is high and no pop occurs.
REQ-022 The occupancy counter SHALL saturate at DEPTH and at 0. The FIFO pointers SHALL wrap modulo DEPTH. A simultaneous push and pop SHALL leave occupancy unchanged.
REQ-023 When the FIFO is empty, op_a and op_b SHALL read 16'h0000.
REQ-024 A byte pair offered with in_valid high and in_ready low SHALL be dropped and SHALL set drop_err. The phase bit SHALL NOT toggle.
REQ-025 frame_clr SHALL force phase to 0 and clear drop_err and the holding registers, while preserving the FIFO contents.
REQ-026 If frame_clr and an accept occur in the same cycle, frame_clr SHALL win and the byte SHALL be discarded.

Reset
REQ-027 When rst_n is low at an edge, the loader SHALL set phase=0, occupancy=0, pointers=0 and drop_err=0. It SHALL clear the holding registers and drive op_valid=0 and op_a=op_b=0.
REQ-028 A reset in mid-pair SHALL discard the pending low byte. The first accepted pair after reset SHALL be treated as a low byte.

Configuration
REQ-029 With AFPM_SPECIAL_DETECT_EN defined, op_zero and op_infnan SHALL be computed from bits [14:10] of A and B at push time and stored per FIFO entry.
REQ-030 Without AFPM_SPECIAL_DETECT_EN, op_zero and op_infnan SHALL be tied to 0 and no flag storage SHALL be synthesised.

Structure
REQ-031 A shared package afpm_pkg SHALL hold the FP16 field constants (EXP_MSB=14, EXP_LSB=10, EXP_MAX=31) and an operand-pair struct type {a, b, zero, infnan}.
REQ-032 The FIFO SHALL be a sub-module afpm_pair_fifo parameterised by DEPTH. The loader SHALL contain the phase logic, the holding registers and the error logic.

Verification
REQ-033 Scenario 1: reset, then pairs (0x71,0x2E) and (0x48,0x48) on consecutive cycles, with op_ready=1 -> op_valid high for 1 cycle, op_a=0x4871, op_b=0x482E, op_zero=0, op_infnan=0.
REQ-034 Scenario 2: op_ready=0, 3 operand pairs with DEPTH=2 -> in_ready low during the third high byte and drop_err=1. Then op_ready=1 -> the first two pairs pop in order.
REQ-035 Scenario 3: full FIFO with op_ready=1 and a high byte presented in the same cycle -> the push is accepted, occupancy stays 2 and no drop occurs.
REQ-036 Scenario 4: A=0x0000, B=0x7C00 with the macro defined -> op_zero=1 and op_infnan=1. Without the macro -> both flags are 0.
REQ-037 Scenario 5: low byte accepted, then rst_n low for 1 cycle, then pairs (0x01,0x01) and (0x3C,0x3C) -> op_a=op_b=0x3C01, with no stale byte.
REQ-038 Scenario 6: low byte accepted, then frame_clr=1 with a simultaneous byte -> the byte is discarded and the next pair is treated as a low byte.

Source files
------------

// File: rtl/afpm_pkg.sv
// Shared FP16 field constants and the operand-pair record for the AFPM operand front end.
package afpm_pkg;

  localparam int unsigned EXP_MSB = 14;
  localparam int unsigned EXP_LSB = 10;
  localparam logic [4:0]  EXP_MAX = 5'd31;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        zero;
    logic        infnan;
  } pair_t;

  function automatic logic exp_is_zero(input logic [15:0] v);
    return v[EXP_MSB:EXP_LSB] == '0;
  endfunction

  function automatic logic exp_is_max(input logic [15:0] v);
    return v[EXP_MSB:EXP_LSB] == EXP_MAX;
  endfunction

endpackage

// File: rtl/afpm_pair_fifo.sv
// Operand-pair FIFO (DEPTH 2 or 4); head reads as zero when empty.
// Per-entry special-value flags exist only with AFPM_SPECIAL_DETECT_EN defined.
module afpm_pair_fifo
  import afpm_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  logic  pop,
  input  pair_t din,
  output pair_t dout,
  output logic  full,
  output logic  empty
);

  localparam int unsigned PW = (DEPTH > 2) ? 2 : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [15:0]   mem_a [DEPTH];
  logic [15:0]   mem_b [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_a[wr_ptr] <= din.a;
      mem_b[wr_ptr] <= din.b;
    end
  end

`ifdef AFPM_SPECIAL_DETECT_EN
  logic mem_zero   [DEPTH];
  logic mem_infnan [DEPTH];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_zero[wr_ptr]   <= din.zero;
      mem_infnan[wr_ptr] <= din.infnan;
    end
  end
`else
  logic unused_flags;
  assign unused_flags = din.zero ^ din.infnan;
`endif

  always_comb begin
    dout = '0;
    if (!empty) begin
      dout.a = mem_a[rd_ptr];
      dout.b = mem_b[rd_ptr];
`ifdef AFPM_SPECIAL_DETECT_EN
      dout.zero   = mem_zero[rd_ptr];
      dout.infnan = mem_infnan[rd_ptr];
`endif
    end
  end

endmodule

// File: rtl/afpm_operand_loader.sv
// Byte-serial FP16 operand loader: pairs low/high bytes, queues operand pairs for the multiplier.
// Optional feature macro: AFPM_SPECIAL_DETECT_EN (zero / inf-NaN exponent flags per entry).
module afpm_operand_loader
  import afpm_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [7:0]  ui_in,
  input  logic [7:0]  uio_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        frame_clr,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic        op_valid,
  input  logic        op_ready,
  output logic        op_zero,
  output logic        op_infnan,
  output logic        drop_err
);

  typedef enum logic {PH_LOW, PH_HIGH} phase_t;

  phase_t     phase;
  logic [7:0] hold_a;
  logic [7:0] hold_b;
  logic       full;
  logic       empty;
  logic       accept;
  logic       push;
  logic       pop;
  pair_t      din;
  pair_t      head;

  assign op_valid  = !empty;
  assign pop       = op_valid && op_ready && ena;
  assign in_ready  = ena && (phase == PH_LOW || !full || (op_valid && op_ready));
  assign accept    = in_valid && in_ready;
  // frame_clr discards whatever byte arrives alongside it, including a high byte.
  assign push      = accept && (phase == PH_HIGH) && !frame_clr;

  assign op_a      = head.a;
  assign op_b      = head.b;
  assign op_zero   = head.zero;
  assign op_infnan = head.infnan;

  always_comb begin
    din   = '0;
    din.a = {ui_in, hold_a};
    din.b = {uio_in, hold_b};
`ifdef AFPM_SPECIAL_DETECT_EN
    din.zero   = exp_is_zero(din.a) || exp_is_zero(din.b);
    din.infnan = exp_is_max(din.a)  || exp_is_max(din.b);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n || frame_clr) begin
      phase    <= PH_LOW;
      hold_a   <= '0;
      hold_b   <= '0;
      drop_err <= 1'b0;
    end else begin
      if (in_valid && !in_ready) drop_err <= 1'b1;
      if (accept) begin
        if (phase == PH_LOW) begin
          hold_a <= ui_in;
          hold_b <= uio_in;
          phase  <= PH_HIGH;
        end else begin
          phase  <= PH_LOW;
        end
      end
    end
  end

  afpm_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

endmodule
